// File: rtl/quicksort_main.sv
// quicksort_main: in-place quicksort of an 8-entry signed byte array held in an
// internal RAM, with a partition stack RAM. Both RAMs are visible on a 2-channel
// byte-wide slave bus. Bus requests are also forwarded unchanged on Mout_*.
// Optional build macro: QSORT_DESCENDING_EN (sort non-increasing instead of ascending).
module quicksort_main #(
    parameter int unsigned MEM_var_28860_28869 = 32,
    parameter int unsigned MEM_var_29120_28866 = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_port,
    input  logic [1:0]  S_oe_ram,
    input  logic [1:0]  S_we_ram,
    input  logic [13:0] S_addr_ram,
    input  logic [15:0] S_Wdata_ram,
    input  logic [7:0]  S_data_ram_size,
    input  logic [15:0] M_Rdata_ram,
    input  logic [1:0]  M_DataRdy,
    output logic        done_port,
    output logic [15:0] Sout_Rdata_ram,
    output logic [1:0]  Sout_DataRdy,
    output logic [1:0]  Mout_oe_ram,
    output logic [1:0]  Mout_we_ram,
    output logic [13:0] Mout_addr_ram,
    output logic [15:0] Mout_Wdata_ram,
    output logic [7:0]  Mout_data_ram_size
);

    localparam logic [6:0] ArrBase = 7'(MEM_var_28860_28869);
    // Equal bases would alias the two RAMs, so the stack moves just past the array.
    localparam logic [6:0] StkBase = (MEM_var_29120_28866 == MEM_var_28860_28869) ?
                                     7'(MEM_var_28860_28869 + 8) : 7'(MEM_var_29120_28866);

    typedef enum logic [3:0] {
        StIdle, StPush0, StPop, StPsetup, StPscan, StPswap, StPfinal, StPush, StFin, StDone
    } state_t;

    state_t            state;
    logic signed [7:0] arr [8];
    logic [7:0]        stk [16];
    logic [3:0]        sp;
    logic [2:0]        lo, hi, j, store;
    logic signed [7:0] pivot;

    logic [6:0] off_arr [2];
    logic [6:0] off_stk [2];
    logic [1:0] arr_hit, stk_hit;
    logic [2:0] arr_idx [2];
    logic [3:0] stk_idx [2];
    logic [7:0] wbyte [2];
    logic [7:0] rd_byte [2];

    logic [2:0] top;
    logic [7:0] pop_lo, pop_hi;
    logic       take;
    logic       left_ok, right_ok;
    logic [3:0] slot_b;

    // Inputs only present for bus symmetry with the master side.
    logic unused_m;
    assign unused_m = ^{M_Rdata_ram, M_DataRdy};

    assign Mout_oe_ram        = S_oe_ram;
    assign Mout_we_ram        = S_we_ram;
    assign Mout_addr_ram      = S_addr_ram;
    assign Mout_Wdata_ram     = S_Wdata_ram;
    assign Mout_data_ram_size = S_data_ram_size;

    // Slave address decode and read mux per channel.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            // Modular offset: addresses below the base wrap high and miss.
            off_arr[c] = S_addr_ram[7*c +: 7] - ArrBase;
            off_stk[c] = S_addr_ram[7*c +: 7] - StkBase;
            arr_hit[c] = off_arr[c] < 7'd8;
            stk_hit[c] = off_stk[c] < 7'd16;
            arr_idx[c] = off_arr[c][2:0];
            stk_idx[c] = off_stk[c][3:0];
            wbyte[c]   = S_Wdata_ram[8*c +: 8];
            if (arr_hit[c])      rd_byte[c] = arr[arr_idx[c]];
            else if (stk_hit[c]) rd_byte[c] = stk[stk_idx[c]];
            else                 rd_byte[c] = 8'd0;
        end
    end

    // Stack top, partition compare and push slot computation.
    always_comb begin
        top    = sp[2:0] - 3'd1;
        pop_lo = stk[{top, 1'b0}];
        pop_hi = stk[{top, 1'b1}];
`ifdef QSORT_DESCENDING_EN
        take   = arr[j] >= pivot;
`else
        take   = arr[j] <= pivot;
`endif
        // store holds the pivot's final index p while in StPush.
        left_ok  = ({1'b0, store} > ({1'b0, lo} + 4'd1)) && (sp < 4'd8);
        slot_b   = sp + {3'b000, left_ok};
        right_ok = ({1'b0, hi} > ({1'b0, store} + 4'd1)) && (slot_b < 4'd8);
    end

    // Sort FSM, RAM storage and bus writes.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= StIdle;
            done_port <= 1'b0;
            sp        <= 4'd0;
            lo        <= 3'd0;
            hi        <= 3'd0;
            j         <= 3'd0;
            store     <= 3'd0;
            pivot     <= 8'sd0;
            arr[0]    <= 8'sd5;
            arr[1]    <= -8'sd3;
            arr[2]    <= 8'sd7;
            arr[3]    <= 8'sd0;
            arr[4]    <= 8'sd127;
            arr[5]    <= -8'sd128;
            arr[6]    <= 8'sd2;
            arr[7]    <= 8'sd2;
            for (int k = 0; k < 16; k++) stk[k] <= 8'd0;
        end else begin
            done_port <= 1'b0;
            unique case (state)
                StIdle: begin
                    // Channel 1 is written last so it wins a same-address collision.
                    for (int c = 0; c < 2; c++) begin
                        if (S_we_ram[c]) begin
                            if (arr_hit[c])      arr[arr_idx[c]] <= wbyte[c];
                            else if (stk_hit[c]) stk[stk_idx[c]] <= wbyte[c];
                        end
                    end
                    if (start_port) state <= StPush0;
                end
                StPush0: begin
                    stk[0] <= 8'd0;
                    stk[1] <= 8'd7;
                    sp     <= 4'd1;
                    state  <= StPop;
                end
                StPop: begin
                    if (sp == 4'd0) begin
                        state <= StFin;
                    end else begin
                        sp <= sp - 4'd1;
                        lo <= pop_lo[2:0];
                        hi <= pop_hi[2:0];
                        if (pop_lo < pop_hi) state <= StPsetup;
                    end
                end
                StPsetup: begin
                    pivot <= arr[hi];
                    store <= lo;
                    j     <= lo;
                    state <= StPscan;
                end
                StPscan: begin
                    if (j < hi) begin
                        if (take) state <= StPswap;
                        else      j <= j + 3'd1;
                    end else begin
                        state <= StPfinal;
                    end
                end
                StPswap: begin
                    arr[store] <= arr[j];
                    arr[j]     <= arr[store];
                    store      <= store + 3'd1;
                    j          <= j + 3'd1;
                    state      <= StPscan;
                end
                StPfinal: begin
                    arr[store] <= arr[hi];
                    arr[hi]    <= arr[store];
                    state      <= StPush;
                end
                StPush: begin
                    if (left_ok) begin
                        stk[{sp[2:0], 1'b0}] <= {5'd0, lo};
                        stk[{sp[2:0], 1'b1}] <= {5'd0, store - 3'd1};
                    end
                    if (right_ok) begin
                        stk[{slot_b[2:0], 1'b0}] <= {5'd0, store + 3'd1};
                        stk[{slot_b[2:0], 1'b1}] <= {5'd0, hi};
                    end
                    sp    <= slot_b + {3'b000, right_ok};
                    state <= StPop;
                end
                StFin: begin
                    done_port <= 1'b1;
                    state     <= StDone;
                end
                StDone: begin
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Registered slave response: read data and ack one cycle after the request.
    always_ff @(posedge clock) begin
        if (!reset) begin
            Sout_Rdata_ram <= 16'd0;
            Sout_DataRdy   <= 2'b00;
        end else begin
            for (int c = 0; c < 2; c++) begin
                Sout_DataRdy[c] <= (arr_hit[c] | stk_hit[c]) &
                                   (S_oe_ram[c] | (S_we_ram[c] & (state == StIdle)));
                Sout_Rdata_ram[8*c +: 8] <= S_oe_ram[c] ? rd_byte[c] : 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_quicksort_main.sv
// Self-checking bench for quicksort_main: directed and random arrays checked
// against a plain sorted reference held in mem[].
module tb_quicksort_main;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start_port = 1'b0;
    logic [1:0]  S_oe_ram = '0;
    logic [1:0]  S_we_ram = '0;
    logic [13:0] S_addr_ram = '0;
    logic [15:0] S_Wdata_ram = '0;
    logic [7:0]  S_data_ram_size = 8'h88;
    logic [15:0] M_Rdata_ram = '0;
    logic [1:0]  M_DataRdy = '0;
    logic        done_port;
    logic [15:0] Sout_Rdata_ram;
    logic [1:0]  Sout_DataRdy;
    logic [1:0]  Mout_oe_ram;
    logic [1:0]  Mout_we_ram;
    logic [13:0] Mout_addr_ram;
    logic [15:0] Mout_Wdata_ram;
    logic [7:0]  Mout_data_ram_size;

    int passed = 0;
    int total = 0;
    int done_cnt = 0;
    int mem [8];

    quicksort_main dut (
        .clock              (clock),
        .reset              (reset),
        .start_port         (start_port),
        .S_oe_ram           (S_oe_ram),
        .S_we_ram           (S_we_ram),
        .S_addr_ram         (S_addr_ram),
        .S_Wdata_ram        (S_Wdata_ram),
        .S_data_ram_size    (S_data_ram_size),
        .M_Rdata_ram        (M_Rdata_ram),
        .M_DataRdy          (M_DataRdy),
        .done_port          (done_port),
        .Sout_Rdata_ram     (Sout_Rdata_ram),
        .Sout_DataRdy       (Sout_DataRdy),
        .Mout_oe_ram        (Mout_oe_ram),
        .Mout_we_ram        (Mout_we_ram),
        .Mout_addr_ram      (Mout_addr_ram),
        .Mout_Wdata_ram     (Mout_Wdata_ram),
        .Mout_data_ram_size (Mout_data_ram_size)
    );

    always #5 clock = ~clock;

    // Done is high for one full cycle, so one falling edge sees each pulse.
    always @(negedge clock) if (done_port === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic void ref_sort();
        for (int a = 0; a < 7; a++) begin
            for (int b = 0; b < 7 - a; b++) begin
                bit swap_needed;
                int t;
`ifdef QSORT_DESCENDING_EN
                swap_needed = mem[b] < mem[b+1];
`else
                swap_needed = mem[b] > mem[b+1];
`endif
                if (swap_needed) begin
                    t = mem[b];
                    mem[b] = mem[b+1];
                    mem[b+1] = t;
                end
            end
        end
    endfunction

    function automatic void set_default();
        mem = '{5, -3, 7, 0, 127, -128, 2, 2};
    endfunction

    task automatic bus_write2(input int a0, input int d0, input int a1, input int d1);
        @(negedge clock);
        S_we_ram    = 2'b11;
        S_addr_ram  = {7'(a1), 7'(a0)};
        S_Wdata_ram = {8'(d1), 8'(d0)};
        @(negedge clock);
        S_we_ram    = 2'b00;
    endtask

    task automatic bus_read2(input int a0, input int a1, output logic [1:0] rdy,
                             output logic signed [7:0] d0, output logic signed [7:0] d1);
        @(negedge clock);
        S_oe_ram   = 2'b11;
        S_addr_ram = {7'(a1), 7'(a0)};
        @(negedge clock);
        rdy = Sout_DataRdy;
        d0  = Sout_Rdata_ram[7:0];
        d1  = Sout_Rdata_ram[15:8];
        S_oe_ram = 2'b00;
    endtask

    task automatic write_mem();
        for (int k = 0; k < 4; k++) bus_write2(32 + k, mem[k], 36 + k, mem[k+4]);
    endtask

    task automatic check_array(input string tag);
        logic [1:0] rdy;
        logic signed [7:0] d0, d1;
        for (int k = 0; k < 4; k++) begin
            bus_read2(32 + k, 36 + k, rdy, d0, d1);
            check({tag, " ack"}, rdy, 2'b11);
            check($sformatf("%s a[%0d]", tag, k), d0, mem[k]);
            check($sformatf("%s a[%0d]", tag, k + 4), d1, mem[k+4]);
        end
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start_port = 1'b1;
        @(negedge clock);
        start_port = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_port !== 1'b1 && n < 3000) begin
            @(negedge clock);
            n++;
        end
        check({tag, " done"}, done_port, 1);
        @(negedge clock);
        check({tag, " done low"}, done_port, 0);
    endtask

    task automatic sort_and_check(input string tag);
        pulse_start();
        wait_done(tag);
        ref_sort();
        check_array(tag);
    endtask

    initial begin
        logic [1:0] rdy;
        logic signed [7:0] d0, d1;
        int cnt0;

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst done", done_port, 0);
        check("rst rdy", Sout_DataRdy, 0);
        check("rst rdata", Sout_Rdata_ram, 0);
        reset = 1'b1;
        set_default();
        check_array("default");

        // Sort reset contents
        sort_and_check("sort default");

        // Already sorted input
        mem = '{1, 2, 3, 4, 5, 6, 7, 8};
        write_mem();
        sort_and_check("sorted in");

        // Reverse input
        mem = '{8, 7, 6, 5, 4, 3, 2, 1};
        write_mem();
        sort_and_check("reverse in");

        // Both channels in one cycle, array ends
        bus_read2(32, 39, rdy, d0, d1);
        check("dual ack", rdy, 2'b11);
        check("dual d0", d0, mem[0]);
        check("dual d1", d1, mem[7]);

        // Unmapped address
        bus_read2(0, 0, rdy, d0, d1);
        check("unmapped ack", rdy, 2'b00);
        check("unmapped data", {d1, d0}, 0);

        // Same-address double write: channel 1 wins
        bus_write2(33, 10, 33, 20);
        mem[1] = 20;
        bus_read2(33, 33, rdy, d0, d1);
        check("collide d0", d0, 20);
        check("collide d1", d1, 20);

        // Random arrays, some with many duplicates
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 8; k++) begin
                if (r % 2 == 0) mem[k] = int'($signed(8'($urandom)));
                else            mem[k] = int'($urandom_range(0, 4)) - 2;
            end
            write_mem();
            sort_and_check($sformatf("rand%0d", r));
        end

        // Reset mid-sort aborts without done
        mem = '{8, 7, 6, 5, 4, 3, 2, 1};
        write_mem();
        cnt0 = done_cnt;
        pulse_start();
        repeat (6) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (100) @(negedge clock);
        check("abort no done", done_cnt - cnt0, 0);
        set_default();
        check_array("after abort");
        sort_and_check("resort");

        // Second start and a write while busy are both ignored
        for (int k = 0; k < 8; k++) mem[k] = int'($signed(8'($urandom)));
        write_mem();
        cnt0 = done_cnt;
        pulse_start();
        repeat (3) @(negedge clock);
        start_port = 1'b1;
        @(negedge clock);
        start_port = 1'b0;
        bus_write2(32, 99, 33, 99);
        wait_done("busy");
        repeat (50) @(negedge clock);
        check("one done", done_cnt - cnt0, 1);
        ref_sort();
        check_array("busy");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
